btn_tx_scheduler: RTL and testbench

//  Shares the UART transmitter among NUM_BTN debounced push-buttons. Each debouncer
//  db_tick is latched as a pending request. A round-robin arbiter picks one request,

---
 rtl/btn_tx_scheduler.sv | 130 +++++++++++++
 tb/tb_btn_tx_scheduler.sv | 450 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/btn_tx_scheduler.sv
// Round-robin scheduler that lets NUM_BTN debounced buttons share one uart_tx.
// Each press is latched, granted in turn, and sent as BASE_CHAR + index, followed by a quiet gap.
module btn_tx_scheduler #(
   parameter int         NUM_BTN   = 4,
   parameter logic [7:0] BASE_CHAR = 8'h30,
   parameter int         GAP_CYC   = 16,
   parameter int         GW        = 8
) (
   input  logic               clk_50Mhz,
   input  logic               rst_n,
   input  logic [NUM_BTN-1:0] db_tick,
   input  logic               tx_busy,
   input  logic               tx_done_tick,
   output logic               tx_start,
   output logic [7:0]         tx_data,
   output logic [NUM_BTN-1:0] pending,
   output logic [2:0]         grant_idx,
   output logic               active,
   output logic [7:0]         drop_cnt
);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      START     = 2'd1,
      WAIT_DONE = 2'd2,
      GAP       = 2'd3
   } state_t;

   state_t             state_r;
   state_t             next_state_s;
   logic [2:0]         rr_ptr_r;
   logic [GW-1:0]      gap_cnt_r;
   logic [NUM_BTN-1:0] pending_r;
   logic [7:0]         tx_data_r;
   logic [7:0]         drop_cnt_r;
   logic [2:0]         grant_idx_r;

   logic [7:0]         pend_ext_s;
   logic [3:0]         cand_s;
   logic               win_found_s;
   logic [2:0]         win_idx_s;
   logic               grant_s;
   logic [7:0]         grant_mask_ext_s;
   logic [NUM_BTN-1:0] grant_mask_s;
   logic               drop_s;

   // Round-robin search: first pending bit at or after rr_ptr_r, wrapping modulo NUM_BTN.
   always_comb begin
      pend_ext_s  = 8'(pending_r);
      cand_s      = 4'd0;
      win_found_s = 1'b0;
      win_idx_s   = 3'd0;
      for (int k = 0; k < NUM_BTN; k++) begin
         cand_s      = {1'b0, rr_ptr_r} + 4'(k);
         cand_s      = (cand_s >= 4'(NUM_BTN)) ? (cand_s - 4'(NUM_BTN)) : cand_s;
         win_idx_s   = (!win_found_s && pend_ext_s[cand_s[2:0]]) ? cand_s[2:0] : win_idx_s;
         win_found_s = win_found_s | pend_ext_s[cand_s[2:0]];
      end
   end

   // Grant qualification, grant mask and drop detection (a tick on the grant cycle re-arms, not drops).
   always_comb begin
      grant_s          = (state_r == IDLE) && win_found_s && !tx_busy;
      grant_mask_ext_s = grant_s ? (8'd1 << win_idx_s) : 8'd0;
      grant_mask_s     = grant_mask_ext_s[NUM_BTN-1:0];
      drop_s           = |(db_tick & pending_r & ~grant_mask_s);
   end

   // Next-state logic.
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         IDLE:      next_state_s = grant_s ? START : IDLE;
         START:     next_state_s = WAIT_DONE;
         WAIT_DONE: begin
            if (tx_done_tick) begin
               next_state_s = (GAP_CYC == 0) ? IDLE : GAP;
            end else begin
               next_state_s = WAIT_DONE;
            end
         end
         GAP:       next_state_s = (gap_cnt_r <= GW'(1)) ? IDLE : GAP;
         default:   next_state_s = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk_50Mhz or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Request latch, drop counter, grant bookkeeping and gap counter.
   always_ff @(posedge clk_50Mhz or negedge rst_n) begin
      if (!rst_n) begin
         pending_r   <= '0;
         drop_cnt_r  <= 8'd0;
         grant_idx_r <= 3'd0;
         tx_data_r   <= 8'd0;
         rr_ptr_r    <= 3'd0;
         gap_cnt_r   <= '0;
      end else begin
         pending_r <= (pending_r & ~grant_mask_s) | db_tick;
         if (drop_s && (drop_cnt_r != 8'hFF)) begin
            drop_cnt_r <= drop_cnt_r + 8'd1;
         end
         if (grant_s) begin
            grant_idx_r <= win_idx_s;
            tx_data_r   <= BASE_CHAR + {5'd0, win_idx_s};
            rr_ptr_r    <= (win_idx_s == 3'(NUM_BTN - 1)) ? 3'd0 : (win_idx_s + 3'd1);
         end
         if ((state_r == WAIT_DONE) && tx_done_tick) begin
            gap_cnt_r <= GW'(GAP_CYC);
         end else if ((state_r == GAP) && (gap_cnt_r != '0)) begin
            gap_cnt_r <= gap_cnt_r - GW'(1);
         end
      end
   end

   assign tx_start  = (state_r == START);
   assign active    = (state_r != IDLE);
   assign tx_data   = tx_data_r;
   assign pending   = pending_r;
   assign grant_idx = grant_idx_r;
   assign drop_cnt  = drop_cnt_r;

endmodule

// File: tb/tb_btn_tx_scheduler.sv
// Self-checking bench for btn_tx_scheduler: a uart_tx model answers each frame and a
// scoreboard of expected button indices is checked at every tx_start.
module tb_btn_tx_scheduler;
   localparam int NUM_BTN   = 4;
   localparam int GAP_CYC   = 16;
   localparam int FRAME_CYC = 10;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic [NUM_BTN-1:0] db_tick = '0;
   logic               uart_busy = 1'b0;
   logic               force_busy = 1'b0;
   logic               tx_busy;
   logic               tx_done_tick = 1'b0;
   logic               tx_start;
   logic [7:0]         tx_data;
   logic [NUM_BTN-1:0] pending;
   logic [2:0]         grant_idx;
   logic               active;
   logic [7:0]         drop_cnt;

   int   checks = 0;
   int   fails = 0;
   int   cyc = 0;
   int   exp_q[$];
   int   last_done_cyc = 0;
   bit   done_valid = 1'b0;
   bit   frame_valid = 1'b0;
   logic [7:0] frame_data = 8'd0;
   int   frame_cnt = 0;

   assign tx_busy = uart_busy | force_busy;

   btn_tx_scheduler #(.NUM_BTN(NUM_BTN), .BASE_CHAR(8'h30), .GAP_CYC(GAP_CYC), .GW(8)) dut (
      .clk_50Mhz(clk), .rst_n(rst_n), .db_tick(db_tick), .tx_busy(tx_busy),
      .tx_done_tick(tx_done_tick), .tx_start(tx_start), .tx_data(tx_data),
      .pending(pending), .grant_idx(grant_idx), .active(active), .drop_cnt(drop_cnt)
   );

   always #10 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // uart_tx model plus scoreboard, evaluated on the falling edge.
   initial begin
      int e;
      logic [7:0] eb;
      forever begin
         @(negedge clk);
         tx_done_tick = 1'b0;
         if (!rst_n) frame_valid = 1'b0;
         if (frame_cnt > 0) begin
            if (frame_valid) begin
               checks++;
               if (tx_data !== frame_data) begin
                  fails++;
                  $display("FAIL tx_data_stable: got %h want %h", tx_data, frame_data);
               end
            end
            frame_cnt--;
            if (frame_cnt == 0) begin
               tx_done_tick  = 1'b1;
               uart_busy     = 1'b0;
               last_done_cyc = cyc;
               done_valid    = 1'b1;
            end
         end
         if (tx_start === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
               fails++;
               $display("FAIL unexpected_start: tx_data=%h grant_idx=%0d with empty scoreboard", tx_data, grant_idx);
            end else begin
               e  = exp_q.pop_front();
               eb = 8'h30 + 8'(e);
               if (tx_data !== eb || grant_idx !== 3'(e)) begin
                  fails++;
                  $display("FAIL frame_order: got data %h idx %0d want data %h idx %0d", tx_data, grant_idx, eb, e);
               end
            end
            if (done_valid) begin
               checks++;
               if (cyc - last_done_cyc < GAP_CYC + 2) begin
                  fails++;
                  $display("FAIL frame_gap: got %0d cycles want >= %0d", cyc - last_done_cyc, GAP_CYC + 2);
               end
            end
            uart_busy   = 1'b1;
            frame_cnt   = FRAME_CYC;
            frame_data  = tx_data;
            frame_valid = 1'b1;
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_uart_idle();
      for (int i = 0; i < 200; i++) begin
         if (!uart_busy) break;
         tick();
      end
      done_valid = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      db_tick = '0;
      force_busy = 1'b0;
      repeat (3) tick();
      rst_n = 1'b1;
      wait_uart_idle();
      exp_q.delete();
   endtask

   task automatic wait_idle(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         if (exp_q.size() == 0 && !uart_busy && !active && pending == '0) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
   endtask

   task automatic wait_start(output bit got);
      got = 1'b0;
      for (int i = 0; i < 300; i++) begin
         if (tx_start === 1'b1) begin
            got = 1'b1;
            break;
         end
         tick();
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #1;
      checks++;
      if ({tx_start, tx_data, pending, grant_idx, active, drop_cnt} !== 24'd0) begin
         fails++;
         $display("FAIL reset_values: got %h want 0", {tx_start, tx_data, pending, grant_idx, active, drop_cnt});
      end
      do_reset();
      tick();
      checks++;
      if (tx_start !== 1'b0 || active !== 1'b0) begin
         fails++;
         $display("FAIL reset_idle: got start %b active %b want 0 0", tx_start, active);
      end
   endtask

   task automatic test_single_press();
      bit got;
      do_reset();
      tick();
      db_tick = 4'b0100;
      exp_q.push_back(2);
      tick();
      db_tick = '0;
      checks++;
      if (pending !== 4'b0100 || tx_start !== 1'b0) begin
         fails++;
         $display("FAIL single_latch: got pending %b start %b want 0100 0", pending, tx_start);
      end
      tick();
      checks++;
      if (tx_start !== 1'b1 || tx_data !== 8'h32 || grant_idx !== 3'd2 || pending !== 4'b0000) begin
         fails++;
         $display("FAIL single_start: got start %b data %h idx %0d pending %b want 1 32 2 0000",
                  tx_start, tx_data, grant_idx, pending);
      end
      got = 1'b0;
      for (int i = 0; i < 100; i++) begin
         if (tx_done_tick === 1'b1) begin
            got = 1'b1;
            break;
         end
         tick();
      end
      checks++;
      if (!got) begin
         fails++;
         $display("FAIL single_done: got no tx_done_tick want one");
      end
      for (int k = 0; k < GAP_CYC; k++) begin
         checks++;
         if (active !== 1'b1) begin
            fails++;
            $display("FAIL gap_active: got active %b at gap cycle %0d want 1", active, k);
         end
         tick();
      end
      checks++;
      if (active !== 1'b0) begin
         fails++;
         $display("FAIL gap_end: got active %b want 0", active);
      end
   endtask

   task automatic test_simultaneous();
      bit ok;
      do_reset();
      tick();
      db_tick = 4'b1111;
      for (int i = 0; i < 4; i++) exp_q.push_back(i);
      tick();
      db_tick = '0;
      wait_idle(ok);
      checks++;
      if (!ok || drop_cnt !== 8'd0) begin
         fails++;
         $display("FAIL simultaneous: got done %b drops %0d left %0d want 1 0 0", ok, drop_cnt, exp_q.size());
      end
   endtask

   task automatic test_fairness();
      bit got;
      bit ok;
      do_reset();
      tick();
      db_tick = 4'b1001;
      exp_q.push_back(0); exp_q.push_back(3); exp_q.push_back(0); exp_q.push_back(3);
      tick();
      db_tick = '0;
      for (int f = 0; f < 4; f++) begin
         wait_start(got);
         checks++;
         if (!got) begin
            fails++;
            $display("FAIL fairness_start: frame %0d got no tx_start want one", f);
         end
         if (f == 0) db_tick = 4'b0001;
         else if (f == 1) db_tick = 4'b1000;
         tick();
         db_tick = '0;
      end
      wait_idle(ok);
      checks++;
      if (!ok) begin
         fails++;
         $display("FAIL fairness_drain: got %0d frames outstanding want 0", exp_q.size());
      end
   endtask

   task automatic test_drops();
      bit ok;
      do_reset();
      force_busy = 1'b1;
      tick();
      db_tick = 4'b1010;
      tick();
      db_tick = 4'b1010;
      tick();
      db_tick = 4'b0010;
      tick();
      db_tick = 4'b0010;
      tick();
      db_tick = '0;
      tick();
      checks++;
      if (drop_cnt !== 8'd3 || pending !== 4'b1010 || active !== 1'b0) begin
         fails++;
         $display("FAIL drop_three: got drops %0d pending %b active %b want 3 1010 0", drop_cnt, pending, active);
      end
      db_tick = 4'b0010;
      force_busy = 1'b0;
      exp_q.push_back(1); exp_q.push_back(3); exp_q.push_back(1);
      tick();
      db_tick = '0;
      checks++;
      if (tx_start !== 1'b1 || pending !== 4'b1010 || drop_cnt !== 8'd3) begin
         fails++;
         $display("FAIL grant_cycle_tick: got start %b pending %b drops %0d want 1 1010 3", tx_start, pending, drop_cnt);
      end
      wait_idle(ok);
      checks++;
      if (!ok) begin
         fails++;
         $display("FAIL drop_drain: got %0d frames outstanding want 0", exp_q.size());
      end
      force_busy = 1'b1;
      db_tick = 4'b0010;
      tick();
      for (int i = 0; i < 100; i++) tick();
      checks++;
      if (drop_cnt !== 8'd103) begin
         fails++;
         $display("FAIL drop_count: got %0d want 103", drop_cnt);
      end
      for (int i = 0; i < 200; i++) tick();
      db_tick = '0;
      tick();
      checks++;
      if (drop_cnt !== 8'd255) begin
         fails++;
         $display("FAIL drop_saturate: got %0d want 255", drop_cnt);
      end
      exp_q.push_back(1);
      force_busy = 1'b0;
      wait_idle(ok);
      checks++;
      if (!ok || drop_cnt !== 8'd255) begin
         fails++;
         $display("FAIL drop_final: got done %b drops %0d want 1 255", ok, drop_cnt);
      end
   endtask

   task automatic test_busy_hold();
      bit ok;
      do_reset();
      force_busy = 1'b1;
      tick();
      db_tick = 4'b0100;
      tick();
      db_tick = '0;
      for (int i = 0; i < 10; i++) begin
         checks++;
         if (tx_start !== 1'b0 || active !== 1'b0) begin
            fails++;
            $display("FAIL busy_hold: got start %b active %b want 0 0", tx_start, active);
         end
         tick();
      end
      force_busy = 1'b0;
      exp_q.push_back(2);
      tick();
      checks++;
      if (tx_start !== 1'b1) begin
         fails++;
         $display("FAIL busy_release: got start %b want 1", tx_start);
      end
      wait_idle(ok);
      checks++;
      if (!ok) begin
         fails++;
         $display("FAIL busy_drain: got %0d frames outstanding want 0", exp_q.size());
      end
   endtask

   task automatic test_reset_mid_frame();
      bit got;
      bit ok;
      do_reset();
      tick();
      db_tick = 4'b0100;
      exp_q.push_back(2);
      tick();
      db_tick = '0;
      wait_start(got);
      tick();
      checks++;
      if (!got || active !== 1'b1) begin
         fails++;
         $display("FAIL wait_done_reach: got start %b active %b want 1 1", got, active);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if ({tx_start, tx_data, pending, grant_idx, active, drop_cnt} !== 24'd0) begin
         fails++;
         $display("FAIL reset_in_wait_done: got %h want 0", {tx_start, tx_data, pending, grant_idx, active, drop_cnt});
      end
      tick();
      tick();
      rst_n = 1'b1;
      wait_uart_idle();
      tick();
      db_tick = 4'b1010;
      exp_q.push_back(1); exp_q.push_back(3);
      tick();
      db_tick = '0;
      wait_idle(ok);
      checks++;
      if (!ok) begin
         fails++;
         $display("FAIL rr_after_reset: got %0d frames outstanding want 0", exp_q.size());
      end
      tick();
      db_tick = 4'b0011;
      exp_q.push_back(0); exp_q.push_back(1);
      tick();
      db_tick = 4'b0010;
      tick();
      db_tick = '0;
      wait_start(got);
      got = 1'b0;
      for (int i = 0; i < 100; i++) begin
         if (tx_done_tick === 1'b1) begin
            got = 1'b1;
            break;
         end
         tick();
      end
      tick();
      tick();
      checks++;
      if (!got || active !== 1'b1 || drop_cnt !== 8'd1 || pending !== 4'b0010) begin
         fails++;
         $display("FAIL gap_reach: got done %b active %b drops %0d pending %b want 1 1 1 0010",
                  got, active, drop_cnt, pending);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if ({tx_start, tx_data, pending, grant_idx, active, drop_cnt} !== 24'd0) begin
         fails++;
         $display("FAIL reset_in_gap: got %h want 0", {tx_start, tx_data, pending, grant_idx, active, drop_cnt});
      end
      exp_q.delete();
      tick();
      tick();
      rst_n = 1'b1;
      wait_uart_idle();
      tick();
      db_tick = 4'b0110;
      exp_q.push_back(1); exp_q.push_back(2);
      tick();
      db_tick = '0;
      wait_idle(ok);
      checks++;
      if (!ok) begin
         fails++;
         $display("FAIL after_gap_reset: got %0d frames outstanding want 0", exp_q.size());
      end
   endtask

   initial begin
      test_reset();
      test_single_press();
      test_simultaneous();
      test_fairness();
      test_drops();
      test_busy_hold();
      test_reset_mid_frame();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
